// File: rtl/uart_msg_rx_pkg.sv
// Shared constants for the UART message receiver: byte FSM encodings, data width
// and the baud divider helper.
package uart_msg_rx_pkg;

    localparam int unsigned DataBits = 8;

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StStart    = 3'd1;
    localparam logic [2:0] StData     = 3'd2;
    localparam logic [2:0] StStop     = 3'd3;
    localparam logic [2:0] StWaitHigh = 3'd4;

    function automatic int unsigned uart_div(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_msg_rx_if.sv
// Line and application-side signals of the UART message receiver.
// The slave modport is the receiver; master is the pad/application side.
interface uart_msg_rx_if #(
    parameter int unsigned MSG_LEN = 4
);
    logic                   rx;
    logic [8*MSG_LEN-1:0]   msg_flat;
    logic                   msg_valid;
    logic [7:0]             last_rx_byte;
    logic                   rcv;
    logic                   frame_err;
    logic                   timeout_err;

    modport master (
        output rx,
        input  msg_flat, msg_valid, last_rx_byte, rcv, frame_err, timeout_err
    );

    modport slave (
        input  rx,
        output msg_flat, msg_valid, last_rx_byte, rcv, frame_err, timeout_err
    );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: rx synchroniser, bit FSM and baud counter.
// byte_ok_o/byte_bad_o are next-state strobes so the assembler can update in step with rcv_o.
module uart_rx_byte
    import uart_msg_rx_pkg::*;
#(
    parameter int unsigned DIV = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic       idle_o,
    output logic       start_o,
    output logic       byte_ok_o,
    output logic       byte_bad_o,
    output logic [7:0] data_o,
    output logic       rcv_o,
    output logic [7:0] last_rx_byte_o,
    output logic       frame_err_o
);
    localparam int unsigned CntW = $clog2(DIV) + 1;
    localparam logic [CntW-1:0] DivFull = CntW'(DIV);
    localparam logic [CntW-1:0] DivHalf = CntW'(DIV / 2);

    logic            rx_meta_q, rx_s_q;
    logic [2:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      byte_q, byte_d;
    logic            rcv_q, ferr_q;
    logic            ok, bad, tick;

    assign tick = (cnt_q == CntW'(1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        ok      = 1'b0;
        bad     = 1'b0;
        case (state_q)
            StIdle: begin
                if (!rx_s_q) begin
                    state_d = StStart;
                    cnt_d   = DivHalf;
                end
            end
            StStart: begin
                if (!tick) begin
                    cnt_d = cnt_q - CntW'(1);
                end else if (rx_s_q) begin
                    state_d = StIdle;
                end else begin
                    state_d = StData;
                    cnt_d   = DivFull;
                    bit_d   = 3'd0;
                end
            end
            StData: begin
                if (!tick) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    cnt_d   = DivFull;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'(DataBits - 1)) state_d = StStop;
                end
            end
            StStop: begin
                if (!tick) begin
                    cnt_d = cnt_q - CntW'(1);
                end else if (rx_s_q) begin
                    ok      = 1'b1;
                    byte_d  = shift_q;
                    state_d = StIdle;
                end else begin
                    bad     = 1'b1;
                    state_d = StWaitHigh;
                end
            end
            // A held-low line (break) must not retrigger a start.
            StWaitHigh: begin
                if (rx_s_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            byte_q    <= '0;
            rcv_q     <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            byte_q    <= byte_d;
            rcv_q     <= ok;
            ferr_q    <= bad;
        end
    end

    assign idle_o         = (state_q == StIdle);
    assign start_o        = (state_q == StIdle) && !rx_s_q;
    assign byte_ok_o      = ok;
    assign byte_bad_o     = bad;
    assign data_o         = shift_q;
    assign rcv_o          = rcv_q;
    assign last_rx_byte_o = byte_q;
    assign frame_err_o    = ferr_q;

endmodule

// File: rtl/uart_msg_rx.sv
// Fixed-length UART message receiver: assembles MSG_LEN good bytes into msg_flat,
// dropping partial messages on framing error or inter-byte timeout.
module uart_msg_rx
    import uart_msg_rx_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 12000000,
    parameter int unsigned BAUD         = 115200,
    parameter int unsigned MSG_LEN      = 4,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic          clk,
    input  logic          rst,
    uart_msg_rx_if.slave  bus
);
    localparam int unsigned DIV      = uart_div(CLK_HZ, BAUD);
    localparam int unsigned CntW     = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam int unsigned TmoLimit = TIMEOUT_BITS * DIV;
    localparam int unsigned TmoW     = $clog2(TmoLimit + 1);
    localparam int unsigned FlatW    = 8 * MSG_LEN;

    logic             idle, start, byte_ok, byte_bad;
    logic [7:0]       byte_data;
    logic             rcv, frame_err;
    logic [7:0]       last_byte;

    logic [CntW-1:0]  count_q, count_d;
    logic [FlatW-1:0] stage_q, stage_d, staged;
    logic [FlatW-1:0] flat_q, flat_d;
    logic             valid_q, valid_d;
    logic [TmoW-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic             tmo_q, tmo_d;

    uart_rx_byte #(
        .DIV (DIV)
    ) u_byte (
        .clk            (clk),
        .rst            (rst),
        .rx_i           (bus.rx),
        .idle_o         (idle),
        .start_o        (start),
        .byte_ok_o      (byte_ok),
        .byte_bad_o     (byte_bad),
        .data_o         (byte_data),
        .rcv_o          (rcv),
        .last_rx_byte_o (last_byte),
        .frame_err_o    (frame_err)
    );

    always_comb begin
        staged = stage_q;
        for (int unsigned i = 0; i < MSG_LEN; i++) begin
            if (count_q == CntW'(i)) staged[8*(MSG_LEN-1-i) +: 8] = byte_data;
        end

        count_d   = count_q;
        stage_d   = stage_q;
        flat_d    = flat_q;
        valid_d   = 1'b0;
        tmo_cnt_d = tmo_cnt_q;
        tmo_d     = 1'b0;

        if (byte_ok) begin
            if (count_q == CntW'(MSG_LEN - 1)) begin
                flat_d  = staged;
                valid_d = 1'b1;
                count_d = '0;
                stage_d = '0;
            end else begin
                count_d = count_q + CntW'(1);
                stage_d = staged;
            end
        end else if (byte_bad) begin
            count_d = '0;
            stage_d = '0;
        end

        // Idle gap is only timed while a partial message is pending.
        if (start || !idle || count_q == '0) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q == TmoW'(TmoLimit - 1)) begin
            tmo_cnt_d = '0;
            tmo_d     = 1'b1;
            count_d   = '0;
            stage_d   = '0;
        end else begin
            tmo_cnt_d = tmo_cnt_q + TmoW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            stage_q   <= '0;
            flat_q    <= '0;
            valid_q   <= 1'b0;
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            stage_q   <= stage_d;
            flat_q    <= flat_d;
            valid_q   <= valid_d;
            tmo_cnt_q <= tmo_cnt_d;
            tmo_q     <= tmo_d;
        end
    end

    assign bus.msg_flat     = flat_q;
    assign bus.msg_valid    = valid_q;
    assign bus.last_rx_byte = last_byte;
    assign bus.rcv          = rcv;
    assign bus.frame_err    = frame_err;
    assign bus.timeout_err  = tmo_q;

endmodule

// File: tb/tb_uart_msg_rx.sv
// Directed bench for uart_msg_rx: a default 4-byte instance (DIV=104) and a
// single-byte instance (DIV=8) fed a random stream.
module tb_uart_msg_rx;
    localparam int unsigned Div0 = 104;
    localparam int unsigned Div1 = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_msg_rx_if #(.MSG_LEN(4)) bus0 ();
    uart_msg_rx_if #(.MSG_LEN(1)) bus1 ();

    uart_msg_rx #(
        .CLK_HZ       (12000000),
        .BAUD         (115200),
        .MSG_LEN      (4),
        .TIMEOUT_BITS (20)
    ) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    uart_msg_rx #(
        .CLK_HZ       (12000000),
        .BAUD         (1500000),
        .MSG_LEN      (1),
        .TIMEOUT_BITS (20)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int total = 0;
    int bad   = 0;

    int n_rcv0 = 0, n_valid0 = 0, n_ferr0 = 0, n_tmo0 = 0, excl0 = 0, vmis0 = 0;
    int n_rcv1 = 0, n_valid1 = 0, vmis1 = 0;

    always @(posedge clk) begin
        if (!rst) begin
            if (bus0.rcv)         n_rcv0++;
            if (bus0.msg_valid)   n_valid0++;
            if (bus0.frame_err)   n_ferr0++;
            if (bus0.timeout_err) n_tmo0++;
            if (bus0.rcv && bus0.frame_err)  excl0++;
            if (bus0.msg_valid && !bus0.rcv) vmis0++;
            if (bus1.rcv)         n_rcv1++;
            if (bus1.msg_valid)   n_valid1++;
            if (bus1.msg_valid !== bus1.rcv) vmis1++;
        end
    end

    task automatic send0(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        bus0.rx = 1'b0;
        repeat (Div0) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus0.rx = b[i];
            repeat (Div0) @(negedge clk);
        end
        bus0.rx = stop_bit;
        repeat (Div0) @(negedge clk);
        bus0.rx = 1'b1;
    endtask

    task automatic send1(input logic [7:0] b);
        @(negedge clk);
        bus1.rx = 1'b0;
        repeat (Div1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus1.rx = b[i];
            repeat (Div1) @(negedge clk);
        end
        bus1.rx = 1'b1;
        repeat (Div1) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (5) @(negedge clk);
        total++;
        if (bus0.msg_flat !== 32'h0) begin
            bad++; $display("FAIL reset_msg_flat: got %h want %h", bus0.msg_flat, 32'h0);
        end
        total++;
        if (bus0.last_rx_byte !== 8'h00) begin
            bad++; $display("FAIL reset_last_byte: got %h want 00", bus0.last_rx_byte);
        end
        total++;
        if ({bus0.rcv, bus0.msg_valid, bus0.frame_err, bus0.timeout_err} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_pulses: got %b want 0000",
                     {bus0.rcv, bus0.msg_valid, bus0.frame_err, bus0.timeout_err});
        end
        total++;
        if ({bus1.msg_flat, bus1.rcv, bus1.msg_valid} !== 10'h0) begin
            bad++; $display("FAIL reset_dut1: got %h want 000", {bus1.msg_flat, bus1.rcv, bus1.msg_valid});
        end
        rst = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int r = n_rcv0, v = n_valid0, f = n_ferr0, t = n_tmo0;
        send0(8'hDE, 1'b1);
        send0(8'hAD, 1'b1);
        send0(8'hBE, 1'b1);
        send0(8'hEF, 1'b1);
        repeat (5) @(negedge clk);
        total++;
        if (n_rcv0 - r != 4) begin
            bad++; $display("FAIL b2b_rcv_count: got %0d want 4", n_rcv0 - r);
        end
        total++;
        if (n_valid0 - v != 1) begin
            bad++; $display("FAIL b2b_valid_count: got %0d want 1", n_valid0 - v);
        end
        total++;
        if (bus0.msg_flat !== 32'hDEADBEEF) begin
            bad++; $display("FAIL b2b_msg_flat: got %h want deadbeef", bus0.msg_flat);
        end
        total++;
        if (bus0.last_rx_byte !== 8'hEF) begin
            bad++; $display("FAIL b2b_last_byte: got %h want ef", bus0.last_rx_byte);
        end
        total++;
        if ((n_ferr0 - f) + (n_tmo0 - t) != 0) begin
            bad++; $display("FAIL b2b_errors: got %0d want 0", (n_ferr0 - f) + (n_tmo0 - t));
        end
    endtask

    task automatic test_frame_err();
        int r = n_rcv0, v = n_valid0, f = n_ferr0;
        send0(8'h99, 1'b1);
        send0(8'h55, 1'b0);
        repeat (2 * Div0) @(negedge clk);
        total++;
        if (n_ferr0 - f != 1) begin
            bad++; $display("FAIL ferr_count: got %0d want 1", n_ferr0 - f);
        end
        total++;
        if (n_rcv0 - r != 1 || bus0.last_rx_byte !== 8'h99) begin
            bad++; $display("FAIL ferr_no_rcv: got rcv=%0d last=%h want 1/99", n_rcv0 - r, bus0.last_rx_byte);
        end
        send0(8'hA5, 1'b1);
        repeat (3) @(negedge clk);
        total++;
        if (bus0.last_rx_byte !== 8'hA5 || n_rcv0 - r != 2) begin
            bad++; $display("FAIL ferr_next_byte: got last=%h rcv=%0d want a5/2", bus0.last_rx_byte, n_rcv0 - r);
        end
        send0(8'h5A, 1'b1);
        send0(8'h0F, 1'b1);
        send0(8'hF0, 1'b1);
        repeat (3) @(negedge clk);
        total++;
        if (bus0.msg_flat !== 32'hA55A0FF0 || n_valid0 - v != 1) begin
            bad++; $display("FAIL ferr_restart_msg: got %h valid=%0d want a55a0ff0/1", bus0.msg_flat, n_valid0 - v);
        end
    endtask

    task automatic test_timeout();
        int v = n_valid0, t = n_tmo0;
        int k = 0;
        send0(8'h11, 1'b1);
        send0(8'h22, 1'b1);
        repeat (1800) @(negedge clk);
        total++;
        if (n_tmo0 - t != 0) begin
            bad++; $display("FAIL tmo_early: got %0d want 0", n_tmo0 - t);
        end
        while (n_tmo0 == t && k < 1000) begin
            @(negedge clk);
            k++;
        end
        repeat (5) @(negedge clk);
        total++;
        if (n_tmo0 - t != 1) begin
            bad++; $display("FAIL tmo_count: got %0d want 1", n_tmo0 - t);
        end
        total++;
        if (bus0.msg_flat !== 32'hA55A0FF0 || n_valid0 != v) begin
            bad++; $display("FAIL tmo_flat_kept: got %h want a55a0ff0", bus0.msg_flat);
        end
        send0(8'h01, 1'b1);
        send0(8'h02, 1'b1);
        send0(8'h03, 1'b1);
        send0(8'h04, 1'b1);
        repeat (3) @(negedge clk);
        total++;
        if (bus0.msg_flat !== 32'h01020304 || n_valid0 - v != 1) begin
            bad++; $display("FAIL tmo_next_msg: got %h valid=%0d want 01020304/1", bus0.msg_flat, n_valid0 - v);
        end
        total++;
        if (n_tmo0 - t != 1) begin
            bad++; $display("FAIL tmo_no_repeat: got %0d want 1", n_tmo0 - t);
        end
    endtask

    task automatic test_false_start();
        int r = n_rcv0, f = n_ferr0;
        @(negedge clk);
        bus0.rx = 1'b0;
        repeat (30) @(negedge clk);
        bus0.rx = 1'b1;
        repeat (200) @(negedge clk);
        total++;
        if (n_rcv0 != r || n_ferr0 != f) begin
            bad++; $display("FAIL glitch_quiet: got rcv=%0d ferr=%0d want 0/0", n_rcv0 - r, n_ferr0 - f);
        end
        send0(8'h3C, 1'b1);
        repeat (3) @(negedge clk);
        total++;
        if (bus0.last_rx_byte !== 8'h3C || n_rcv0 - r != 1 || n_ferr0 != f) begin
            bad++;
            $display("FAIL glitch_next_byte: got last=%h rcv=%0d ferr=%0d want 3c/1/0",
                     bus0.last_rx_byte, n_rcv0 - r, n_ferr0 - f);
        end
    endtask

    task automatic test_reset_mid();
        int r, v;
        logic [7:0] part = 8'h99;
        send0(8'h77, 1'b1);
        @(negedge clk);
        bus0.rx = 1'b0;
        repeat (Div0) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            bus0.rx = part[i];
            repeat (Div0) @(negedge clk);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (bus0.msg_flat !== 32'h0 || bus0.last_rx_byte !== 8'h00) begin
            bad++; $display("FAIL rst_mid_outputs: got %h/%h want 0/0", bus0.msg_flat, bus0.last_rx_byte);
        end
        bus0.rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        r = n_rcv0;
        v = n_valid0;
        send0(8'hCA, 1'b1);
        send0(8'hFE, 1'b1);
        send0(8'hBA, 1'b1);
        send0(8'hBE, 1'b1);
        repeat (3) @(negedge clk);
        total++;
        if (bus0.msg_flat !== 32'hCAFEBABE || n_valid0 - v != 1 || n_rcv0 - r != 4) begin
            bad++;
            $display("FAIL rst_mid_fresh_msg: got %h valid=%0d rcv=%0d want cafebabe/1/4",
                     bus0.msg_flat, n_valid0 - v, n_rcv0 - r);
        end
        total++;
        if (excl0 != 0 || vmis0 != 0) begin
            bad++; $display("FAIL pulse_rules: got excl=%0d vmis=%0d want 0/0", excl0, vmis0);
        end
    endtask

    task automatic test_msg_len1();
        int r = n_rcv1, v = n_valid1;
        logic [7:0] b;
        for (int i = 0; i < 256; i++) begin
            b = 8'($urandom);
            send1(b);
            total++;
            if (bus1.msg_flat !== b || bus1.last_rx_byte !== b) begin
                bad++;
                $display("FAIL len1_byte%0d: got flat=%h last=%h want %h",
                         i, bus1.msg_flat, bus1.last_rx_byte, b);
            end
        end
        repeat (5) @(negedge clk);
        total++;
        if (n_rcv1 - r != 256 || n_valid1 - v != 256) begin
            bad++; $display("FAIL len1_counts: got rcv=%0d valid=%0d want 256/256", n_rcv1 - r, n_valid1 - v);
        end
        total++;
        if (vmis1 != 0) begin
            bad++; $display("FAIL len1_coincide: got %0d want 0", vmis1);
        end
    endtask

    initial begin
        bus0.rx = 1'b1;
        bus1.rx = 1'b1;
        test_reset();
        test_back_to_back();
        test_frame_err();
        test_timeout();
        test_false_start();
        test_reset_mid();
        test_msg_len1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_msg_rx.md
Name: uart_msg_rx

Overview:
- Receive side of the team's fixed-length UART message path.
- Deserialises 8N1 bytes from the rx pin and assembles MSG_LEN bytes into one flat message vector.
- Pulses msg_valid when a message completes; msg_flat uses the same layout the transmit-side uart takes as its msg_flat input.
- Sits between the rx pad and the application logic; a partial message is discarded on framing error or inter-byte timeout.

Parameters:
- CLK_HZ, 12000000, system clock frequency in Hz.
- BAUD, 115200, line rate. DIV = CLK_HZ/BAUD, integer-truncated; 104 at the defaults. DIV must be ≥ 4.
- MSG_LEN, 4, bytes per message; must be ≥ 1.
- TIMEOUT_BITS, 20, idle bit-times allowed between bytes of one message before the partial message is dropped.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- rx  in  1  asynchronous UART line, idles high
- msg_flat  out  8*MSG_LEN  last complete message; first received byte in [8*MSG_LEN-1 -: 8], last byte in [7:0]
- msg_valid  out  1  one-cycle pulse when msg_flat is updated
- last_rx_byte  out  8  most recent good byte
- rcv  out  1  one-cycle pulse per good byte
- frame_err  out  1  one-cycle pulse on a bad stop bit
- timeout_err  out  1  one-cycle pulse when a partial message is dropped

Behaviour:
- Interfaces: one clock domain. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: msg_flat=0, last_rx_byte=0; all pulse outputs 0. FSM=IDLE; byte count=0; all counters=0; synchroniser flops=1.
- Input synchronisation: rx passes through a 2-flop synchroniser, giving rx_s. All decisions use rx_s.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: rx_s=0 → START, baud counter loaded with DIV/2.
- START: when the counter expires, sample rx_s.
  - Sample = 1: false start, return to IDLE with no pulse.
  - Sample = 0: go to DATA, counter reloaded with DIV.
- DATA: sample 8 bits, one every DIV cycles, LSB first, into a shift register. After bit 7 → STOP, counter reloaded with DIV.
- STOP: sample rx_s when the counter expires.
  - Sample = 1: next cycle rcv=1 and last_rx_byte=byte; go to IDLE.
  - Sample = 0: next cycle frame_err=1; byte discarded; byte count cleared to 0; go to WAIT_HIGH.
- WAIT_HIGH: stays until rx_s=1, then → IDLE. This prevents a break condition from retriggering START.
- Latency: rcv asserts exactly 1 cycle after the stop-bit sample, i.e. about 9.5*DIV+3 cycles after the rx falling edge.
- Assembly: a staging register accumulates bytes at index byte count; byte count wraps 0..MSG_LEN-1.
  - On the good byte that completes a message (count = MSG_LEN-1): in the same cycle as rcv, the full staging contents go to msg_flat atomically, msg_valid=1, and count → 0.
  - msg_flat otherwise holds its value; it never shows a partial message.
  - MSG_LEN=1: msg_valid coincides with every rcv.
- Timeout: an idle counter runs while FSM=IDLE and count>0; it clears on any start detection.
  - On reaching TIMEOUT_BITS*DIV: timeout_err pulses, count → 0, staging contents are discarded, msg_flat is unchanged.
  - With count=0 the counter does not run, so no timeout is possible.
- Simultaneous events: frame_err and rcv are mutually exclusive. The timeout cannot coincide with a byte completion, because it is only counted in IDLE.
- Reset mid-operation: an in-flight byte or partial message is lost, with no pulses. The first START is accepted only after rx_s has fallen following reset release; the synchroniser resets to 1.
- Widths: the baud counter is $clog2(DIV)+1 bits. The timeout counter is sized for TIMEOUT_BITS*DIV with no wrap. The byte counter is $clog2(MSG_LEN) bits, minimum 1.

Decomposition:
- Shared package/include (include/modules.vh): UART_DIV function, FSM state encodings, data-bit count constant (8).
- One natural sub-module, uart_rx_byte. It contains the synchroniser, FSM and baud counter, and outputs rcv, last_rx_byte and frame_err.
- uart_msg_rx wraps uart_rx_byte and adds the assembler and timeout logic.

Test Plan:
- Defaults (DIV=104). Send bytes 0xDE, 0xAD, 0xBE, 0xEF back-to-back → four rcv pulses; msg_valid once; msg_flat=0xDEADBEEF; no err pulses.
- Send 0x55 with the stop bit driven 0, then rx high, then 0xA5 → frame_err once; no rcv for 0x55; rcv with last_rx_byte=0xA5; byte count restarted, so 0xA5 is message byte 0.
- Send 0x11, 0x22, then idle 20*104 cycles → timeout_err once; msg_flat unchanged. The next four bytes 0x01–0x04 give msg_flat=0x01020304.
- Drive a rx low glitch of 30 cycles in IDLE → false start; no rcv or frame_err; a following byte 0x3C is received correctly.
- Assert rst during DATA of the 3rd byte, then send four fresh bytes → outputs 0 while rst is high; the new message is assembled from the fresh bytes only.
- MSG_LEN=1, BAUD giving DIV=8, random 256-byte stream → msg_valid coincides with every rcv; msg_flat equals each byte sent.
